// File: rtl/dt_scan_scheduler.sv
// Two-pass (forward then backward) raster-scan sequencer for the distance-transform result RAM.
// Optional build macro DT_SKIP_UNCHANGED_EN suppresses write-back when the distance is unchanged.
module dt_scan_scheduler #(
  parameter int IMG_W  = 128,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                res_rd,
  output logic                res_wr,
  output logic [ADDR_W-1:0]   res_addr,
  output logic [DATA_W-1:0]   res_do,
  input  logic [DATA_W-1:0]   res_di,
  output logic                win_valid,
  input  logic                win_ready,
  output logic                win_pass,
  output logic [DATA_W-1:0]   win_center,
  output logic [4*DATA_W-1:0] win_nb,
  input  logic                dt_valid,
  input  logic [DATA_W-1:0]   dt_value
);

  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] FIRST = CW'(1);
  localparam logic [CW-1:0] LAST  = CW'(IMG_W - 2);

  typedef enum logic [3:0] {
    IDLE, RD_C, CAP_C, RD_N, CAP_N, OFFER, WAIT, WR, ADV, FIN
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     row, col, nb_row, nb_col;
  logic [1:0]        idx;
  logic              pass;
  logic [DATA_W-1:0] dt_lat;
  logic              last_px;
  logic              write_en;
  logic [ADDR_W-1:0] centre_addr, nb_addr;

  assign win_pass    = pass;
  assign centre_addr = ADDR_W'({row, col});
  assign nb_addr     = ADDR_W'({nb_row, nb_col});
  assign last_px     = pass ? (row == FIRST && col == FIRST) : (row == LAST && col == LAST);

`ifdef DT_SKIP_UNCHANGED_EN
  assign write_en = (dt_lat != win_center);
`else
  assign write_en = 1'b1;
`endif

  // Neighbour n[idx]: forward looks up/left, backward looks down/right.
  always_comb begin
    nb_row = row;
    nb_col = col;
    case ({pass, idx})
      3'b000:  begin nb_row = row - ONE; nb_col = col - ONE; end
      3'b001:  nb_row = row - ONE;
      3'b010:  begin nb_row = row - ONE; nb_col = col + ONE; end
      3'b011:  nb_col = col - ONE;
      3'b100:  nb_col = col + ONE;
      3'b101:  begin nb_row = row + ONE; nb_col = col - ONE; end
      3'b110:  nb_row = row + ONE;
      default: begin nb_row = row + ONE; nb_col = col + ONE; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    res_rd    = 1'b0;
    res_wr    = 1'b0;
    res_addr  = '0;
    res_do    = '0;
    win_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RD_C;
      end
      RD_C: begin
        res_rd    = 1'b1;
        res_addr  = centre_addr;
        state_nxt = CAP_C;
      end
      CAP_C: state_nxt = (res_di == '0) ? ADV : RD_N;
      RD_N: begin
        res_rd   = 1'b1;
        res_addr = nb_addr;
        if (idx == 2'd3) state_nxt = CAP_N;
      end
      CAP_N: state_nxt = OFFER;
      OFFER: begin
        win_valid = 1'b1;
        if (win_ready) state_nxt = WAIT;
      end
      WAIT: if (dt_valid) state_nxt = WR;
      WR: begin
        res_addr  = centre_addr;
        res_do    = dt_lat;
        res_wr    = write_en;
        state_nxt = ADV;
      end
      ADV: state_nxt = (pass && last_px) ? FIN : RD_C;
      FIN: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Read data arrives one cycle after its strobe, so neighbour k is captured while k+1 is read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row        <= '0;
      col        <= '0;
      idx        <= '0;
      pass       <= 1'b0;
      dt_lat     <= '0;
      win_center <= '0;
      win_nb     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pass <= 1'b0;
          row  <= FIRST;
          col  <= FIRST;
        end
        CAP_C: begin
          win_center <= res_di;
          idx        <= '0;
        end
        RD_N: begin
          case (idx)
            2'd1:    win_nb[0*DATA_W +: DATA_W] <= res_di;
            2'd2:    win_nb[1*DATA_W +: DATA_W] <= res_di;
            2'd3:    win_nb[2*DATA_W +: DATA_W] <= res_di;
            default: ;
          endcase
          idx <= idx + 2'd1;
        end
        CAP_N: win_nb[3*DATA_W +: DATA_W] <= res_di;
        WAIT: if (dt_valid) dt_lat <= dt_value;
        ADV: begin
          if (!pass) begin
            if (col == LAST) begin
              if (row == LAST) begin
                pass <= 1'b1;
                row  <= LAST;
                col  <= LAST;
              end else begin
                row <= row + ONE;
                col <= FIRST;
              end
            end else begin
              col <= col + ONE;
            end
          end else if (col == FIRST) begin
            if (row != FIRST) begin
              row <= row - ONE;
              col <= LAST;
            end
          end else begin
            col <= col - ONE;
          end
        end
        FIN: pass <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_scan_scheduler.sv
// Scoreboard bench for dt_scan_scheduler on a 16x16 image: a pixel-level scan model queues
// expected reads, windows and writes; a monitor pops and compares them as the DUT produces them.
module tb_dt_scan_scheduler;

  localparam int W          = 16;
  localparam int AW         = 8;
  localparam int DW         = 8;
  localparam int N          = W * W;
  localparam int SCAN_LIMIT = 20000;

  logic          clk, reset, start, busy, done, res_rd, res_wr;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_do;
  logic [DW-1:0] res_di = '0;
  logic          win_valid, win_ready, win_pass;
  logic [DW-1:0] win_center;
  logic [4*DW-1:0] win_nb;
  logic          dt_valid;
  logic [DW-1:0] dt_value;

  dt_scan_scheduler #(.IMG_W(W), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do), .res_di(res_di),
    .win_valid(win_valid), .win_ready(win_ready), .win_pass(win_pass),
    .win_center(win_center), .win_nb(win_nb), .dt_valid(dt_valid), .dt_value(dt_value)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [0:N-1];
  logic          loadEn;
  logic [AW-1:0] loadAddr;
  logic [DW-1:0] loadData;

  int initImg [N];
  int refImg  [N];
  int dR [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  int dC [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

  int          expRd[$];
  int          expWr[$];
  logic [40:0] expWin[$];

  bit sbOn;
  int readyMode, latMax;
  bit junkEn;
  int doneCount = 0, busyCount = 0, stallCount = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Result RAM: one-cycle read latency, preloaded through a side port while the DUT idles.
  always @(posedge clk) begin
    if (loadEn) mem[loadAddr] <= loadData;
    else begin
      if (res_rd) res_di <= mem[res_addr];
      if (res_wr) mem[res_addr] <= res_do;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int dpResult(input int c, input int n0, input int n1, input int n2, input int n3);
    int m;
    m = n0;
    if (n1 < m) m = n1;
    if (n2 < m) m = n2;
    if (n3 < m) m = n3;
    return (m + 1 < c) ? m + 1 : c;
  endfunction

  function automatic logic [63:0] outVec();
    return 64'({busy, done, res_rd, res_wr, win_valid, win_pass, res_addr, res_do, win_center, win_nb});
  endfunction

  // Reference scan: visits pixels in pass order and applies each write before later reads.
  task automatic buildModel(output int cycles, output int wins);
    int r, c, a, ctr, d, na;
    int n [4];
    bit doWrite;
    cycles = 0;
    wins   = 0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < (W-2)*(W-2); k++) begin
        r = (p == 0) ? 1 + k / (W-2) : (W-2) - k / (W-2);
        c = (p == 0) ? 1 + k % (W-2) : (W-2) - k % (W-2);
        a = r * W + c;
        ctr = refImg[a];
        expRd.push_back(a);
        if (ctr == 0) begin
          cycles += 3;
          continue;
        end
        for (int j = 0; j < 4; j++) begin
          na = (r + dR[p*4+j]) * W + c + dC[p*4+j];
          n[j] = refImg[na];
          expRd.push_back(na);
        end
        expWin.push_back({p[0], 8'(ctr), 8'(n[3]), 8'(n[2]), 8'(n[1]), 8'(n[0])});
        d = dpResult(ctr, n[0], n[1], n[2], n[3]);
        doWrite = 1'b1;
`ifdef DT_SKIP_UNCHANGED_EN
        doWrite = (d != ctr);
`endif
        if (doWrite) expWr.push_back(a * 256 + d);
        refImg[a] = d;
        cycles += 11;
        wins++;
      end
    end
  endtask

  task automatic loadRam();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      loadEn   = 1'b1;
      loadAddr = AW'(i);
      loadData = DW'(initImg[i]);
    end
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  task automatic clearImg();
    for (int i = 0; i < N; i++) initImg[i] = 0;
  endtask

  task automatic randImg();
    for (int i = 0; i < N; i++)
      initImg[i] = ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, 255));
  endtask

  task automatic applyStimulus(input int mode, input int lat, input bit junk, input bit checkCycles,
                               output int wins, output int stalls);
    int b0, d0, s0, cyc, diff, expCycles;
    readyMode = mode;
    latMax    = lat;
    junkEn    = junk;
    loadRam();
    refImg = initImg;
    buildModel(expCycles, wins);
    sbOn = 1'b1;
    b0 = busyCount;
    d0 = doneCount;
    s0 = stallCount;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (doneCount == d0 && cyc < SCAN_LIMIT) begin
      @(negedge clk);
      cyc++;
      start = junk && (cyc % 397 == 5) && busy;
    end
    start = 1'b0;
    checkOutput("doneWithinLimit", 64'(cyc < SCAN_LIMIT), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("donePulses", 64'(doneCount - d0), 64'd1);
    checkOutput("readsLeft", 64'(expRd.size()), 64'd0);
    checkOutput("writesLeft", 64'(expWr.size()), 64'd0);
    checkOutput("windowsLeft", 64'(expWin.size()), 64'd0);
    diff = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== DW'(refImg[i])) diff++;
    checkOutput("finalImage", 64'(diff), 64'd0);
    if (checkCycles) checkOutput("busyCycles", 64'(busyCount - b0), 64'(expCycles));
    stalls = stallCount - s0;
    sbOn = 1'b0;
    expRd.delete();
    expWr.delete();
    expWin.delete();
  endtask

  // Datapath stand-in: drives win_ready per mode, returns min/+1 after a random latency and
  // fires stray dt_valid pulses only while the scheduler cannot be in WAIT.
  initial begin
    bit pending;
    int latLeft, pendVal, held;
    win_ready = 1'b0;
    dt_valid  = 1'b0;
    dt_value  = '0;
    pending   = 1'b0;
    latLeft   = 0;
    pendVal   = 0;
    held      = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        win_ready = 1'b0;
        dt_valid  = 1'b0;
        pending   = 1'b0;
        held      = 0;
      end else if (pending) begin
        win_ready = 1'b0;
        if (latLeft == 0) begin
          dt_valid = 1'b1;
          dt_value = DW'(pendVal);
          pending  = 1'b0;
        end else begin
          dt_valid = 1'b0;
          latLeft--;
        end
      end else begin
        case (readyMode)
          0: win_ready = 1'b1;
          1: win_ready = 1'($urandom_range(0, 1));
          default: begin
            win_ready = (held >= 20);
            if (!win_valid) held = 0;
            else if (!win_ready) held++;
          end
        endcase
        dt_valid = junkEn && ($urandom_range(0, 3) == 0);
        dt_value = DW'($urandom_range(0, 255));
        if (win_valid && win_ready) begin
          pending = 1'b1;
          held    = 0;
          latLeft = int'($urandom_range(0, latMax));
          pendVal = dpResult(int'(win_center), int'(win_nb[7:0]), int'(win_nb[15:8]),
                             int'(win_nb[23:16]), int'(win_nb[31:24]));
        end
      end
    end
  end

  // Monitor: protocol rules every cycle, scoreboard pops on each read, write and accepted window.
  initial begin
    logic [40:0] prevWin, curWin;
    bit prevStall;
    int e;
    prevWin   = '0;
    prevStall = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      curWin = {win_pass, win_center, win_nb};
      if (!reset) begin
        prevStall = 1'b0;
      end else begin
        if (done) begin
          doneCount++;
          checkOutput("busyLowInDone", 64'(busy), 64'd0);
        end
        if (busy) busyCount++;
        if (res_rd || res_wr) checkOutput("rdWrExclusive", 64'(res_rd && res_wr), 64'd0);
        if (win_valid) checkOutput("noRamDuringOffer", 64'(res_rd || res_wr), 64'd0);
        if (prevStall) begin
          checkOutput("winValidHeld", 64'(win_valid), 64'd1);
          checkOutput("winStable", 64'(curWin), 64'(prevWin));
        end
        if (win_valid && !win_ready) stallCount++;
        prevStall = win_valid && !win_ready;
        prevWin   = curWin;
        if (sbOn) begin
          if (res_rd) begin
            e = (expRd.size() > 0) ? expRd.pop_front() : -1;
            checkOutput("readAddr", 64'(res_addr), 64'(e));
          end
          if (res_wr) begin
            e = (expWr.size() > 0) ? expWr.pop_front() : -1;
            checkOutput("writeAddrData", 64'({res_addr, res_do}), 64'(e));
          end
          if (win_valid && win_ready) begin
            if (expWin.size() > 0) checkOutput("window", 64'(curWin), 64'(expWin.pop_front()));
            else checkOutput("windowUnexpected", 64'(curWin), 64'hFFFF_FFFF_FFFF_FFFF);
          end
        end
      end
    end
  end

  initial begin
    int wins, stalls;
    reset     = 1'b0;
    start     = 1'b0;
    loadEn    = 1'b0;
    loadAddr  = '0;
    loadData  = '0;
    sbOn      = 1'b0;
    readyMode = 0;
    latMax    = 0;
    junkEn    = 1'b0;
    repeat (3) @(negedge clk);
    #1 checkOutput("resetOutputs", outVec(), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 checkOutput("idleOutputs", outVec(), 64'd0);

    $display("[TB] all-background image");
    clearImg();
    applyStimulus(0, 0, 1'b0, 1'b1, wins, stalls);
    checkOutput("bgWindows", 64'(stalls), 64'd0);

    $display("[TB] single object pixel at first forward position");
    clearImg();
    initImg[W+1] = 1;
    applyStimulus(0, 0, 1'b0, 1'b1, wins, stalls);

    $display("[TB] single object pixel at first backward position");
    clearImg();
    initImg[(W-2)*W + (W-2)] = 1;
    applyStimulus(0, 0, 1'b0, 1'b1, wins, stalls);

    $display("[TB] window held while win_ready stays low");
    clearImg();
    initImg[5*W+5] = 200;
    initImg[4*W+4] = 3;
    applyStimulus(2, 2, 1'b0, 1'b0, wins, stalls);
    checkOutput("stallCycles", 64'(stalls), 64'(20 * wins));

    $display("[TB] reset during neighbour reads");
    clearImg();
    initImg[W+1] = 5;
    readyMode = 0;
    junkEn    = 1'b0;
    loadRam();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 checkOutput("rstCentreRead", 64'({res_rd, res_addr}), 64'({1'b1, AW'(W+1)}));
    @(negedge clk);
    @(negedge clk);
    #1 checkOutput("rstNb0Read", 64'({res_rd, res_addr}), 64'({1'b1, AW'(0)}));
    #1 reset = 1'b0;
    #1 checkOutput("rstImmediate", outVec(), 64'd0);
    @(negedge clk);
    #1 checkOutput("rstNextCycle", outVec(), 64'd0);
    checkOutput("rstNoWrite", 64'(mem[W+1]), 64'd5);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 1'b0, 1'b1, wins, stalls);

    for (int t = 0; t < 3; t++) begin
      $display("[TB] random image %0d", t);
      randImg();
      applyStimulus(1, 4, 1'b1, 1'b0, wins, stalls);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
